// File: rtl/quiz_round_controller.sv
// Round sequencer for the decimal-to-binary trainer: LFSR target, submit grading, score and verdict hold.
// Optional macro ROUND_TIMER_EN adds a per-round answer time limit that forces a wrong verdict on expiry.
module quiz_round_controller #(
    parameter int         TICKS_PER_SEC = 100000000,
    parameter int         RESULT_TICKS  = 50000000,
    parameter int         MAX_ROUNDS    = 10,
    parameter logic [9:0] LFSR_SEED     = 10'h1A5,
    parameter int         ROUND_SECONDS = 15
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       start,
    input  logic       submit,
    input  logic [9:0] switches,
    output logic [9:0] target,
    output logic [3:0] score,
    output logic [3:0] round_num,
    output logic       result_ok,
    output logic       result_bad,
    output logic       game_over,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD      = 3'd1,
        S_WAIT      = 3'd2,
        S_CHECK     = 3'd3,
        S_SHOW      = 3'd4,
        S_GAME_OVER = 3'd5
    } state_t;

    localparam int         HW         = $clog2(RESULT_TICKS + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(RESULT_TICKS - 1);
    localparam logic [3:0] LAST_ROUND = 4'(MAX_ROUNDS);

    if (MAX_ROUNDS < 1 || MAX_ROUNDS > 15 || RESULT_TICKS < 1 || LFSR_SEED == 10'd0 ||
        TICKS_PER_SEC < 1 || ROUND_SECONDS < 1) begin : g_param_check
        $error("quiz_round_controller: parameter out of range");
    end

    state_t        state, state_n;
    logic [9:0]    lfsr;
    logic [2:0]    start_sync, submit_sync;
    logic          start_p, submit_p;
    logic [HW-1:0] hold_cnt, hold_n;
    logic [9:0]    target_n;
    logic [3:0]    score_n, round_n;
    logic          ok_n, bad_n, over_n;
    logic          answer_ok;

    // Two sync flops, third flop remembers the previous level for edge detection.
    assign start_p   = start_sync[1] & ~start_sync[2];
    assign submit_p  = submit_sync[1] & ~submit_sync[2];
    assign state_dbg = state;

`ifdef ROUND_TIMER_EN
    localparam int         TW        = $clog2(TICKS_PER_SEC + 1);
    localparam int         SW        = $clog2(ROUND_SECONDS + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_SEC - 1);
    localparam logic [SW-1:0] SEC_LAST  = SW'(ROUND_SECONDS - 1);

    logic [TW-1:0] tick_cnt, tick_n;
    logic [SW-1:0] sec_cnt, sec_n;
    logic          timed_out, timed_out_n;
    logic          expire;

    assign expire    = (tick_cnt == TICK_LAST) && (sec_cnt == SEC_LAST);
    assign answer_ok = (switches == target) && !timed_out;
`else
    assign answer_ok = (switches == target);
`endif

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            target      <= '0;
            score       <= '0;
            round_num   <= '0;
            result_ok   <= 1'b0;
            result_bad  <= 1'b0;
            game_over   <= 1'b0;
            hold_cnt    <= '0;
            lfsr        <= LFSR_SEED;
            start_sync  <= '0;
            submit_sync <= '0;
`ifdef ROUND_TIMER_EN
            tick_cnt    <= '0;
            sec_cnt     <= '0;
            timed_out   <= 1'b0;
`endif
        end else begin
            state       <= state_n;
            target      <= target_n;
            score       <= score_n;
            round_num   <= round_n;
            result_ok   <= ok_n;
            result_bad  <= bad_n;
            game_over   <= over_n;
            hold_cnt    <= hold_n;
            lfsr        <= {lfsr[8:0], lfsr[9] ^ lfsr[6]};
            start_sync  <= {start_sync[1:0], start};
            submit_sync <= {submit_sync[1:0], submit};
`ifdef ROUND_TIMER_EN
            tick_cnt    <= tick_n;
            sec_cnt     <= sec_n;
            timed_out   <= timed_out_n;
`endif
        end
    end

    always_comb begin
        state_n  = state;
        target_n = target;
        score_n  = score;
        round_n  = round_num;
        ok_n     = result_ok;
        bad_n    = result_bad;
        over_n   = game_over;
        hold_n   = hold_cnt;
`ifdef ROUND_TIMER_EN
        tick_n      = tick_cnt;
        sec_n       = sec_cnt;
        timed_out_n = timed_out;
`endif
        case (state)
            S_IDLE: begin
                if (start_p) begin
                    score_n = '0;
                    round_n = 4'd1;
                    state_n = S_LOAD;
                end
            end
            S_LOAD: begin
                target_n = lfsr;
                state_n  = S_WAIT;
`ifdef ROUND_TIMER_EN
                tick_n      = '0;
                sec_n       = '0;
                timed_out_n = 1'b0;
`endif
            end
            S_WAIT: begin
                // A submit on the expiry cycle is graded normally.
                if (submit_p) begin
                    state_n = S_CHECK;
                end
`ifdef ROUND_TIMER_EN
                else if (expire) begin
                    state_n     = S_CHECK;
                    timed_out_n = 1'b1;
                end else if (tick_cnt == TICK_LAST) begin
                    tick_n = '0;
                    sec_n  = sec_cnt + 1'b1;
                end else begin
                    tick_n = tick_cnt + 1'b1;
                end
`endif
            end
            S_CHECK: begin
                hold_n  = '0;
                state_n = S_SHOW;
                if (answer_ok) begin
                    ok_n = 1'b1;
                    if (score != 4'd15) score_n = score + 4'd1;
                end else begin
                    bad_n = 1'b1;
                end
            end
            S_SHOW: begin
                if (hold_cnt == HOLD_LAST) begin
                    ok_n  = 1'b0;
                    bad_n = 1'b0;
                    if (round_num == LAST_ROUND) begin
                        over_n  = 1'b1;
                        state_n = S_GAME_OVER;
                    end else begin
                        round_n = round_num + 4'd1;
                        state_n = S_LOAD;
                    end
                end else begin
                    hold_n = hold_cnt + 1'b1;
                end
            end
            S_GAME_OVER: begin
                if (start_p) begin
                    over_n  = 1'b0;
                    score_n = '0;
                    round_n = 4'd1;
                    state_n = S_LOAD;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_quiz_round_controller.sv
// Directed bench for quiz_round_controller: reset, grading, verdict hold, game over/restart,
// held-button and ignored-start behaviour, mid-round reset and (with ROUND_TIMER_EN) timeout.
module tb_quiz_round_controller;

    localparam int         TPS  = 10;
    localparam int         RT   = 4;
    localparam int         MR   = 3;
    localparam int         RS   = 2;
    localparam logic [9:0] SEED = 10'h1A5;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_CHECK = 3'd3;
    localparam logic [2:0] ST_SHOW  = 3'd4;
    localparam logic [2:0] ST_OVER  = 3'd5;

    logic       clk_in = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       submit = 1'b0;
    logic [9:0] switches = '0;
    logic [9:0] target;
    logic [3:0] score, round_num;
    logic       result_ok, result_bad, game_over;
    logic [2:0] state_dbg;

    int         tests_run = 0;
    int         tests_failed = 0;
    int         cyc;
    logic [9:0] model_lfsr;
    logic [9:0] cur_t;
    logic [9:0] exp_q[$];

    quiz_round_controller #(
        .TICKS_PER_SEC(TPS),
        .RESULT_TICKS (RT),
        .MAX_ROUNDS   (MR),
        .LFSR_SEED    (SEED),
        .ROUND_SECONDS(RS)
    ) dut (
        .clk_in    (clk_in),
        .reset     (reset),
        .start     (start),
        .submit    (submit),
        .switches  (switches),
        .target    (target),
        .score     (score),
        .round_num (round_num),
        .result_ok (result_ok),
        .result_bad(result_bad),
        .game_over (game_over),
        .state_dbg (state_dbg)
    );

    // ---- clock / reference LFSR ----
    always #5 clk_in = ~clk_in;

    always @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            model_lfsr <= SEED;
            cyc        <= 0;
        end else begin
            model_lfsr <= {model_lfsr[8:0], model_lfsr[9] ^ model_lfsr[6]};
            cyc        <= cyc + 1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, required run to finish");
        $fatal(1);
    end

    // ---- driver tasks ----
    task automatic tick(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    // Pulse reaches the FSM on the 3rd edge; the following cycle is LOAD.
    task automatic press_start();
        start = 1'b1;
        tick(3);
        exp_q.push_back(model_lfsr);
        tick(1);
        start = 1'b0;
        cur_t = exp_q.pop_front();
    endtask

    // Returns on the first SHOW cycle.
    task automatic press_submit();
        submit = 1'b1;
        tick(4);
        submit = 1'b0;
    endtask

    // Called on a LOAD cycle; returns on the first WAIT cycle with the new target.
    task automatic take_load();
        exp_q.push_back(model_lfsr);
        tick(1);
        cur_t = exp_q.pop_front();
    endtask

    // ---- tests ----
    task automatic test_reset();
        tick(2);
        tests_run++;
        if ({target, score, round_num, result_ok, result_bad, game_over, state_dbg} !== '0) begin
            tests_failed++;
            $display("FAIL reset_state: got t=%h s=%0d r=%0d ok=%b bad=%b go=%b st=%0d, want all 0",
                     target, score, round_num, result_ok, result_bad, game_over, state_dbg);
        end
        @(negedge clk_in);
        reset = 1'b1;
        tick(1);
        while (cyc < 20) tick(1);
    endtask

    task automatic test_first_round();
        press_start();
        tests_run++;
        if (target !== cur_t) begin
            tests_failed++;
            $display("FAIL first_target: got %h want %h", target, cur_t);
        end
        tests_run++;
        if (round_num !== 4'd1 || score !== 4'd0 || state_dbg !== ST_WAIT) begin
            tests_failed++;
            $display("FAIL first_round: got r=%0d s=%0d st=%0d want r=1 s=0 st=%0d",
                     round_num, score, state_dbg, ST_WAIT);
        end
    endtask

    task automatic test_correct();
        switches = cur_t;
        press_submit();
        tests_run++;
        if (result_ok !== 1'b1 || result_bad !== 1'b0 || score !== 4'd1) begin
            tests_failed++;
            $display("FAIL correct_verdict: got ok=%b bad=%b s=%0d want ok=1 bad=0 s=1",
                     result_ok, result_bad, score);
        end
        tick(3);
        tests_run++;
        if (result_ok !== 1'b1) begin
            tests_failed++;
            $display("FAIL correct_hold_last: got ok=%b want 1", result_ok);
        end
        tick(1);
        tests_run++;
        if (result_ok !== 1'b0 || round_num !== 4'd2 || state_dbg !== ST_LOAD) begin
            tests_failed++;
            $display("FAIL correct_release: got ok=%b r=%0d st=%0d want ok=0 r=2 st=%0d",
                     result_ok, round_num, state_dbg, ST_LOAD);
        end
        take_load();
        tests_run++;
        if (target !== cur_t) begin
            tests_failed++;
            $display("FAIL second_target: got %h want %h", target, cur_t);
        end
    endtask

    task automatic test_wrong();
        switches = cur_t ^ 10'h001;
        press_submit();
        tests_run++;
        if (result_bad !== 1'b1 || result_ok !== 1'b0 || score !== 4'd1) begin
            tests_failed++;
            $display("FAIL wrong_verdict: got ok=%b bad=%b s=%0d want ok=0 bad=1 s=1",
                     result_ok, result_bad, score);
        end
        tick(3);
        tests_run++;
        if (result_bad !== 1'b1) begin
            tests_failed++;
            $display("FAIL wrong_hold_last: got bad=%b want 1", result_bad);
        end
        tick(1);
        tests_run++;
        if (result_bad !== 1'b0 || round_num !== 4'd3 || score !== 4'd1) begin
            tests_failed++;
            $display("FAIL wrong_release: got bad=%b r=%0d s=%0d want bad=0 r=3 s=1",
                     result_bad, round_num, score);
        end
        take_load();
    endtask

    task automatic test_game_over();
        logic [9:0] held;
        held     = cur_t;
        switches = cur_t;
        press_submit();
        tick(4);
        tests_run++;
        if (game_over !== 1'b1 || score !== 4'd2 || state_dbg !== ST_OVER || target !== held) begin
            tests_failed++;
            $display("FAIL game_over_first: got go=%b s=%0d st=%0d t=%h want go=1 s=2 st=%0d t=%h",
                     game_over, score, state_dbg, target, ST_OVER, held);
        end
        press_start();
        tests_run++;
        if (game_over !== 1'b0 || score !== 4'd0 || round_num !== 4'd1 || target !== cur_t) begin
            tests_failed++;
            $display("FAIL restart: got go=%b s=%0d r=%0d t=%h want go=0 s=0 r=1 t=%h",
                     game_over, score, round_num, target, cur_t);
        end
        for (int r = 1; r <= MR; r++) begin
            switches = cur_t;
            press_submit();
            tick(4);
            if (r < MR) take_load();
        end
        tests_run++;
        if (game_over !== 1'b1 || score !== 4'd3 || round_num !== 4'd3) begin
            tests_failed++;
            $display("FAIL all_correct: got go=%b s=%0d r=%0d want go=1 s=3 r=3",
                     game_over, score, round_num);
        end
        press_start();
        tests_run++;
        if (game_over !== 1'b0 || score !== 4'd0 || round_num !== 4'd1 || target !== cur_t) begin
            tests_failed++;
            $display("FAIL restart_after_win: got go=%b s=%0d r=%0d t=%h want go=0 s=0 r=1 t=%h",
                     game_over, score, round_num, target, cur_t);
        end
    endtask

    task automatic test_held_submit();
        int checks;
        checks   = 0;
        switches = cur_t;
        submit   = 1'b1;
        for (int i = 1; i <= 50; i++) begin
            tick(1);
            if (state_dbg === ST_CHECK && i <= 25) checks++;
            if (i == 8) exp_q.push_back(model_lfsr);
        end
        submit = 1'b0;
        tick(3);
        cur_t = exp_q.pop_front();
        tests_run++;
        if (checks !== 1) begin
            tests_failed++;
            $display("FAIL held_submit_checks: got %0d CHECK cycles want 1", checks);
        end
        tests_run++;
        if (score !== 4'd1 || round_num !== 4'd2 || state_dbg !== ST_WAIT || target !== cur_t) begin
            tests_failed++;
            $display("FAIL held_submit_after: got s=%0d r=%0d st=%0d t=%h want s=1 r=2 st=%0d t=%h",
                     score, round_num, state_dbg, target, ST_WAIT, cur_t);
        end
        start = 1'b1;
        tick(6);
        start = 1'b0;
        tick(3);
        tests_run++;
        if (state_dbg !== ST_WAIT || round_num !== 4'd2 || score !== 4'd1 || target !== cur_t) begin
            tests_failed++;
            $display("FAIL start_in_wait: got st=%0d r=%0d s=%0d t=%h want st=%0d r=2 s=1 t=%h",
                     state_dbg, round_num, score, target, ST_WAIT, cur_t);
        end
    endtask

    task automatic test_reset_mid_show();
        switches = cur_t ^ 10'h3FF;
        press_submit();
        tests_run++;
        if (result_bad !== 1'b1 || state_dbg !== ST_SHOW || score !== 4'd1) begin
            tests_failed++;
            $display("FAIL mid_show_setup: got bad=%b st=%0d s=%0d want bad=1 st=%0d s=1",
                     result_bad, state_dbg, score, ST_SHOW);
        end
        tick(1);
        #2 reset = 1'b0;
        #1;
        tests_run++;
        if ({target, score, round_num, result_ok, result_bad, game_over, state_dbg} !== '0) begin
            tests_failed++;
            $display("FAIL mid_show_reset: got t=%h s=%0d r=%0d ok=%b bad=%b go=%b st=%0d, want all 0",
                     target, score, round_num, result_ok, result_bad, game_over, state_dbg);
        end
        @(negedge clk_in);
        reset = 1'b1;
        tick(2);
        press_start();
        tests_run++;
        if (score !== 4'd0 || round_num !== 4'd1 || target !== cur_t || state_dbg !== ST_WAIT) begin
            tests_failed++;
            $display("FAIL after_reset_start: got s=%0d r=%0d t=%h st=%0d want s=0 r=1 t=%h st=%0d",
                     score, round_num, target, state_dbg, cur_t, ST_WAIT);
        end
    endtask

`ifdef ROUND_TIMER_EN
    task automatic test_timeout();
        int k;
        k        = 0;
        switches = cur_t;
        while (result_bad !== 1'b1 && k < 40) begin
            tick(1);
            k++;
        end
        tests_run++;
        if (k !== (TPS * RS) + 1) begin
            tests_failed++;
            $display("FAIL timeout_latency: got bad after %0d cycles want %0d", k, (TPS * RS) + 1);
        end
        tests_run++;
        if (result_bad !== 1'b1 || result_ok !== 1'b0 || score !== 4'd0) begin
            tests_failed++;
            $display("FAIL timeout_verdict: got ok=%b bad=%b s=%0d want ok=0 bad=1 s=0",
                     result_ok, result_bad, score);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_first_round();
        test_correct();
        test_wrong();
        test_game_over();
        test_held_submit();
        test_reset_mid_show();
`ifdef ROUND_TIMER_EN
        test_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
